adder_seq_ctrl: RTL and testbench

Sequencing controller that time-multiplexes one shared 4-bit ripple-carry adder (`adder`) to add or subtract multi-nibble operands, one nibble per clock, least-significant nibble first. It sits between a requesting unit and the adder instance. It accepts a request through a start/ready handshake, drives the adder's A/B/Cin inputs, and captures S/Cout into a result register. It then reports completion with a one-cycle `done` pulse.

---
 rtl/adder_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: time-multiplexes one external 4-bit ripple-carry adder
// to add/subtract NIBBLES-nibble operands, LS nibble first.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, sub          request (taken when start && ready), 0=A+B 1=A-B
//   op_a, op_b          W-bit operands, sampled at accept
//   ready, busy, done   IDLE / RUN+DONE / one-cycle completion pulse
//   result, carry       W-bit result and final Cout (sub: 1 = no borrow)
//   add_a/add_b/add_cin drive to the shared adder (zero outside RUN)
//   add_s/add_cout      adder sum and carry out
//   ovf                 signed overflow (only with ADDER_SEQ_OVF_EN)
//
// Optional feature macro: ADDER_SEQ_OVF_EN adds the registered ovf output.

module adder_seq_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          c_q, c_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  result_q, result_d;

    logic          accept;
    logic          in_run;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [IW+1:0] nib_lsb;

    assign accept  = start && (state_q == S_IDLE);
    assign in_run  = (state_q == S_RUN);
    assign nib_lsb = {idx_q, 2'b00};
    assign nib_a   = a_q[nib_lsb +: 4];
    assign nib_b   = b_q[nib_lsb +: 4];

    // Adder inputs are forced to zero outside RUN so the shared adder
    // sees a quiet bus whenever this block is not using it.
    assign add_a   = in_run ? nib_a : 4'd0;
    assign add_b   = in_run ? nib_b : 4'd0;
    assign add_cin = in_run ? c_q   : 1'b0;

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign carry  = c_q;

`ifdef ADDER_SEQ_OVF_EN
    logic ovf_q, ovf_d;
    logic c3;

    // Carry into bit 3 recovered from the sum bit: s3 = a3 ^ b3 ^ c3.
    assign c3  = add_a[3] ^ add_b[3] ^ add_s[3];
    assign ovf = ovf_q;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        idx_d    = idx_q;
        result_d = result_q;
`ifdef ADDER_SEQ_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Subtraction is A + ~B + 1: invert B, seed Cin.
                    a_d      = op_a;
                    b_d      = sub ? ~op_b : op_b;
                    c_d      = sub;
                    idx_d    = '0;
                    result_d = '0;
`ifdef ADDER_SEQ_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[nib_lsb +: 4] = add_s;
                c_d = add_cout;
`ifdef ADDER_SEQ_OVF_EN
                // Only the last nibble's value survives to DONE.
                ovf_d = c3 ^ add_cout;
`endif
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

`ifdef ADDER_SEQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: scoreboard bench for adder_seq_ctrl (NIBBLES=4)
// with a behavioural 4-bit adder model on the adder ports.

module tb_adder_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
`ifdef ADDER_SEQ_OVF_EN
    logic         ovf;
`endif

    adder_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
`ifdef ADDER_SEQ_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    // Shared 4-bit adder model.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, carry, result}
    logic [W+1:0] sb_q[$];

    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic s);
        logic [W-1:0] bb;
        logic [W:0]   sum;
        logic         ov;
        bb  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        ov  = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
        return {ov, sum[W], sum[W-1:0]};
    endfunction

    // Scoreboard consumer: compare on every done cycle.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [W+1:0] e;
                e = sb_q.pop_front();
                check("result", 64'(result), 64'(e[W-1:0]));
                check("carry", 64'(carry), 64'(e[W]));
`ifdef ADDER_SEQ_OVF_EN
                check("ovf", 64'(ovf), 64'(e[W+1]));
`endif
            end
        end
    end

    // Starts while ready=1, away from the edge; ends 1ns after T0+NIB+1.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [3:0] cin_exp,
                         input bit chk_cin);
        check("pre_ready", 64'(ready), 64'd1);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sub   = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb_q.push_back(model(a, b, s));
        check("busy_after_accept", 64'(busy), 64'd1);
        for (int k = 0; k < NIB; k++) begin
            if (chk_cin) check("add_cin", 64'(add_cin), 64'(cin_exp[k]));
            @(posedge clk);
            #1;
        end
        check("done_pulse", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        check("done_clear", 64'(done), 64'd0);
        check("ready_back", 64'(ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #3;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_carry", 64'(carry), 64'd0);
        check("rst_adder", 64'({add_a, add_b, add_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h1234, 16'h4321, 1'b0, 4'b0000, 1'b1);
        do_op(16'hFFFF, 16'h0001, 1'b0, 4'b1110, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1, 4'b0000, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b1, 4'b0000, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 4'b0000, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 4'b0000, 1'b0);
        check("idle_adder", 64'({add_a, add_b, add_cin}), 64'd0);

        // start held high through RUN and DONE
        start = 1'b1;
        op_a  = 16'h1111;
        op_b  = 16'h2222;
        sub   = 1'b0;
        @(posedge clk);
        #1;
        sb_q.push_back(model(16'h1111, 16'h2222, 1'b0));
        op_a = 16'hAAAA;
        op_b = 16'h0101;
        sub  = 1'b1;
        for (int k = 0; k < NIB; k++) begin
            check("hold_busy", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
        end
        check("hold_done", 64'(done), 64'd1);
        check("hold_not_ready", 64'(ready), 64'd0);
        @(posedge clk);
        #1;
        check("hold_idle_ready", 64'(ready), 64'd1);
        check("hold_idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("hold_second_accept", 64'(busy), 64'd1);
        sb_q.push_back(model(16'hAAAA, 16'h0101, 1'b1));
        start = 1'b0;
        for (int k = 0; k < NIB; k++) begin
            @(posedge clk);
            #1;
        end
        check("second_done", 64'(done), 64'd1);
        @(posedge clk);
        #1;

        // reset after nibble 1 is captured
        start = 1'b1;
        op_a  = 16'h1234;
        op_b  = 16'h1111;
        sub   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb_q.push_back(model(16'h1234, 16'h1111, 1'b0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_partial", 64'(result[7:0]), 64'h45);
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd1);
        check("mid_rst_carry", 64'(carry), 64'd0);
        check("mid_rst_adder", 64'({add_a, add_b, add_cin}), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_no_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < NIB + 2; k++) begin
            @(negedge clk);
            check("post_rst_no_done", 64'(done), 64'd0);
        end
        do_op(16'h0F0F, 16'h0101, 1'b0, 4'b0000, 1'b0);
        do_op(16'h1234, 16'h4321, 1'b0, 4'b0000, 1'b0);

        @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
